// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable frequency divider.
// Each channel runs an IDLE/RUN state machine with a counter that wraps at the
// active divisor N. It produces a divided waveform (high for ceil(N/2) cycles)
// and a one-cycle tick at the start of every period.
// Divisor changes and enable/disable take effect only at period boundaries.
// A sync-clear strobe restarts all running channels in phase.
// Optional feature macro: CLK_DIV_ODD_50_DUTY_EN. When it is defined, odd
// divisors get exactly 50% duty through a falling-edge copy of the waveform.
module clk_div_prog #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_CH-1:0]         i_en,
    input  logic [NUM_CH-1:0]         i_load,
    input  logic [NUM_CH*CNT_W-1:0]   i_div,
    input  logic                      i_sync_clr,
    output logic [NUM_CH-1:0]         o_clk_div,
    output logic [NUM_CH-1:0]         o_tick,
    output logic [NUM_CH-1:0]         o_active
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(2);

    // High-phase length ceil(n/2). One extra bit keeps n = 2^CNT_W-1 from overflowing.
    function automatic logic [CNT_W:0] half_up(input logic [CNT_W-1:0] n);
        return ({1'b0, n} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           r_state, w_state_nxt;
        logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
        logic [CNT_W-1:0] r_div, w_div_nxt;
        logic [CNT_W-1:0] r_pend, w_pend_nxt;
        logic             r_pvld, w_pvld_nxt;
        logic             r_clk, w_clk_nxt;
        logic             r_tick, w_tick_nxt;
        logic [CNT_W-1:0] w_ld_div;
        logic [CNT_W-1:0] w_new_div;
        logic             w_bound;

        assign w_ld_div = i_div[c*CNT_W +: CNT_W];

        // Next-state logic: counting, boundary handling, divisor staging, and the next output values.
        always_comb begin
            // NOTE: every signal driven here gets a default first so no path infers a latch.
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_div_nxt   = r_div;
            w_pend_nxt  = r_pend;
            w_pvld_nxt  = r_pvld;
            w_new_div   = r_div;
            w_bound     = 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Idle channels take a load straight into the active divisor.
                    w_pvld_nxt = 1'b0;
                    if (i_load[c]) begin
                        w_div_nxt = w_ld_div;
                    end
                    if (i_en[c] && (w_div_nxt >= DIV_MIN)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    // A sync clear counts as a period boundary and overrides the normal wrap.
                    w_bound = i_sync_clr || (r_cnt == (r_div - CNT_ONE));
                    if (w_bound) begin
                        // This boundary applies the old pending value.
                        // A load on the same edge is held for the next boundary.
                        w_new_div  = r_pvld ? r_pend : r_div;
                        w_div_nxt  = w_new_div;
                        w_cnt_nxt  = '0;
                        w_pvld_nxt = i_load[c];
                        if (i_load[c]) begin
                            w_pend_nxt = w_ld_div;
                        end
                        if (!i_en[c] || (w_new_div < DIV_MIN)) begin
                            w_state_nxt = ST_IDLE;
                            // Once idle there is no boundary left to wait for.
                            // A coincident load becomes the active divisor.
                            if (i_load[c]) begin
                                w_div_nxt  = w_ld_div;
                                w_pvld_nxt = 1'b0;
                            end
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (i_load[c]) begin
                            w_pend_nxt = w_ld_div;
                            w_pvld_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            w_clk_nxt  = (w_state_nxt == ST_RUN) && ({1'b0, w_cnt_nxt} < half_up(w_div_nxt));
            w_tick_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt == '0);
        end

        // State register: every per-channel register, outputs included, updates on the rising edge.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments.
            // All flops then update together from the pre-edge values.
            if (!i_rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_div   <= DEF_DIV_W;
                r_pend  <= '0;
                r_pvld  <= 1'b0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_div   <= w_div_nxt;
                r_pend  <= w_pend_nxt;
                r_pvld  <= w_pvld_nxt;
                r_clk   <= w_clk_nxt;
                r_tick  <= w_tick_nxt;
            end
        end

`ifdef CLK_DIV_ODD_50_DUTY_EN
        logic r_clk_fall;

        // Falling-edge copy of the waveform, half a cycle behind the rising-edge flop.
        always_ff @(negedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_clk_fall <= 1'b0;
            end else begin
                r_clk_fall <= r_clk;
            end
        end

        // For odd N, ANDing with the delayed copy trims half a cycle from the high phase.
        // That leaves exactly N/2 cycles high.
        assign o_clk_div[c] = (r_state == ST_RUN && r_div[0]) ? (r_clk & r_clk_fall) : r_clk;
`else
        assign o_clk_div[c] = r_clk;
`endif
        assign o_tick[c]   = r_tick;
        assign o_active[c] = (r_state == ST_RUN);
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog (default build, odd-duty feature off).
// Inputs change on the falling edge and outputs are sampled there, so the DUT's rising edge never races with the bench.
module tb_clk_div_prog;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*CNT_W-1:0] div;
    logic                    sync_clr;
    logic [NUM_CH-1:0]       clk_div;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       active;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clk_div_prog #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(2)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_load    (load),
        .i_div     (div),
        .i_sync_clr(sync_clr),
        .o_clk_div (clk_div),
        .o_tick    (tick),
        .o_active  (active)
    );

    // Advance one rising edge and stop at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input int ch, input int cyc,
                          input logic e_clk, input logic e_tick, input logic e_act);
        check($sformatf("%s clk ch%0d c%0d", tag, ch, cyc), 32'(clk_div[ch]), 32'(e_clk));
        check($sformatf("%s tick ch%0d c%0d", tag, ch, cyc), 32'(tick[ch]), 32'(e_tick));
        check($sformatf("%s act ch%0d c%0d", tag, ch, cyc), 32'(active[ch]), 32'(e_act));
    endtask

    task automatic do_reset();
        en       = '0;
        load     = '0;
        div      = '0;
        sync_clr = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_div(input int ch, input int val);
        div[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic load_idle(input int ch, input int val);
        load[ch] = 1'b1;
        set_div(ch, val);
        step();
        load = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = '0;
        load     = '0;
        div      = '0;
        sync_clr = 1'b0;
        step();

        // Reset state
        check("rst clk_div", 32'(clk_div), 32'h0);
        check("rst tick", 32'(tick), 32'h0);
        check("rst active", 32'(active), 32'h0);
        rst_n = 1'b1;
        step();

        // T1: default divisor 2 on ch0, first high cycle right after the enable edge
        en[0] = 1'b1;
        check("t1 latency", 32'(clk_div[0]), 32'h0);
        step();
        for (int i = 0; i < 6; i++) begin
            chk_ch("t1", 0, i, (i % 2) == 0, (i % 2) == 0, 1'b1);
            step();
        end

        // T2: load 5 while idle, then enable -> high 3, low 2, tick every 5
        do_reset();
        load_idle(1, 5);
        check("t2 idle after load", 32'(active[1]), 32'h0);
        en[1] = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            chk_ch("t2", 1, i, (i % 5) < 3, (i % 5) == 0, 1'b1);
            step();
        end

        // T3: ch2 at 6, load 3 during cnt==2 -> the 6-period completes, then 3-periods
        do_reset();
        load_idle(2, 6);
        en[2] = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            if (i < 6) begin
                chk_ch("t3", 2, i, i < 3, i == 0, 1'b1);
            end else begin
                chk_ch("t3", 2, i, ((i - 6) % 3) < 2, ((i - 6) % 3) == 0, 1'b1);
            end
            if (i == 2) begin
                load[2] = 1'b1;
                set_div(2, 3);
            end else begin
                load = '0;
            end
            step();
        end

        // T4: ch0 at 4, ch1 at 6, out of phase; sync clear aligns ticks, which coincide every 12
        do_reset();
        load[0] = 1'b1;
        load[1] = 1'b1;
        set_div(0, 4);
        set_div(1, 6);
        step();
        load  = '0;
        en[0] = 1'b1;
        step();
        en[1] = 1'b1;
        step();
        step();
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        for (int j = 0; j < 25; j++) begin
            chk_ch("t4", 0, j, (j % 4) < 2, (j % 4) == 0, 1'b1);
            chk_ch("t4", 1, j, (j % 6) < 3, (j % 6) == 0, 1'b1);
            if (j == 0) begin
                check("t4 idle untouched", 32'(active[3:2]), 32'h0);
            end
            step();
        end

        // T5a: ch3 at 8, disable at cnt==1 -> 6 more cycles, then idle
        do_reset();
        load_idle(3, 8);
        en[3] = 1'b1;
        step();
        for (int i = 0; i < 11; i++) begin
            chk_ch("t5a", 3, i, i < 4, i == 0, i < 8);
            if (i == 1) begin
                en[3] = 1'b0;
            end
            step();
        end

        // T5b: load 1 on the running ch3 -> idle at the boundary, even with the enable held high
        en[3] = 1'b1;
        step();
        for (int i = 0; i < 11; i++) begin
            chk_ch("t5b", 3, i, i < 4, i == 0, i < 8);
            if (i == 2) begin
                load[3] = 1'b1;
                set_div(3, 1);
            end else begin
                load = '0;
            end
            step();
        end
        en = '0;

        // T6: reset at cnt==3 of 7 -> outputs drop asynchronously; divisor returns to 2
        do_reset();
        load_idle(2, 7);
        en[2] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_ch("t6", 2, i, 1'b1, i == 0, 1'b1);
            if (i < 3) begin
                step();
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async clk_div", 32'(clk_div), 32'h0);
        check("t6 async tick", 32'(tick), 32'h0);
        check("t6 async active", 32'(active), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_ch("t6 def", 2, i, (i % 2) == 0, (i % 2) == 0, 1'b1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
